rename_ctrl: RTL and testbench

RENAME_CTRL -- requirements
Module: rename_ctrl

---
 rtl/rename_ctrl_if.sv | 35 +++
 rtl/rename_ctrl.sv | 107 ++++++++++
 tb/tb_rename_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rename_ctrl_if.sv
// Dispatch, RAT, ROB and flush signals between decode/ROB and the rename controller.
interface rename_ctrl_if #(
  parameter int ROBSIZE = 8
);
  logic               i_valid;
  logic               o_ready;
  logic               i_rd_we;
  logic [4:0]         i_rd;
  logic               o_rat_we;
  logic [4:0]         o_rat_rd;
  logic [ROBSIZE-1:0] o_rat_rob_addr;
  logic               o_rat_rob_or_rf;
  logic               o_rob_alloc_en;
  logic [ROBSIZE-1:0] o_rob_alloc_addr;
  logic               i_commit_en;
  logic [ROBSIZE-1:0] i_commit_rob_addr;
  logic               i_flush;
  logic               o_rat_flush;
  logic [ROBSIZE:0]   o_count;
  logic               o_err;

  // Decode/ROB side: drives requests, commits and flushes.
  modport master (
    output i_valid, i_rd_we, i_rd, i_commit_en, i_commit_rob_addr, i_flush,
    input  o_ready, o_rat_we, o_rat_rd, o_rat_rob_addr, o_rat_rob_or_rf,
           o_rob_alloc_en, o_rob_alloc_addr, o_rat_flush, o_count, o_err
  );

  // Rename controller side.
  modport slave (
    input  i_valid, i_rd_we, i_rd, i_commit_en, i_commit_rob_addr, i_flush,
    output o_ready, o_rat_we, o_rat_rd, o_rat_rob_addr, o_rat_rob_or_rf,
           o_rob_alloc_en, o_rob_alloc_addr, o_rat_flush, o_count, o_err
  );
endinterface

// File: rtl/rename_ctrl.sv
// Rename controller: allocates ROB tags at dispatch, writes the RAT,
// tracks ROB occupancy and commit order, and sequences pipeline flushes.
module rename_ctrl #(
  parameter int ROBSIZE     = 8,
  parameter int ROB_DEPTH   = 8,
  parameter int HOLD_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  rename_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

  localparam logic [ROBSIZE:0]   FULL      = (ROBSIZE+1)'(ROB_DEPTH);
  localparam logic [ROBSIZE:0]   CNT_ONE   = (ROBSIZE+1)'(1);
  localparam logic [ROBSIZE-1:0] PTR_LAST  = ROBSIZE'(ROB_DEPTH - 1);
  localparam logic [ROBSIZE-1:0] PTR_ONE   = ROBSIZE'(1);
  localparam logic [3:0]         HOLD_INIT = 4'(HOLD_CYCLES);

  state_t             state;
  logic [ROBSIZE-1:0] head;
  logic [ROBSIZE-1:0] tail;
  logic [ROBSIZE:0]   count;
  logic               err;
  logic               rat_flush;
  logic [3:0]         hold_cnt;

  logic ready;
  logic accept;
  logic commit;
  logic rat_we;

  function automatic logic [ROBSIZE-1:0] ptr_next(input logic [ROBSIZE-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Handshake and commit qualification; a same-cycle commit never frees a slot for dispatch.
  always_comb begin
    ready  = (state == RUN) & ~bus.i_flush & (count != FULL);
    accept = bus.i_valid & ready;
    commit = bus.i_commit_en & (state == RUN) & ~bus.i_flush & (count != '0);
    rat_we = accept & bus.i_rd_we & (bus.i_rd != 5'd0);
  end

  assign bus.o_ready          = ready;
  assign bus.o_rob_alloc_en   = accept;
  assign bus.o_rob_alloc_addr = tail;
  assign bus.o_rat_we         = rat_we;
  assign bus.o_rat_rd         = rat_we ? bus.i_rd : 5'd0;
  assign bus.o_rat_rob_addr   = rat_we ? tail : '0;
  assign bus.o_rat_rob_or_rf  = rat_we;
  assign bus.o_rat_flush      = rat_flush;
  assign bus.o_count          = count;
  assign bus.o_err            = err;

  // Control FSM plus ROB pointers; the ROB is cleared on the edge that enters FLUSH,
  // so the flush pulse and the zeroed occupancy appear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      err       <= 1'b0;
      rat_flush <= 1'b0;
      hold_cnt  <= '0;
    end else if (bus.i_flush) begin
      state     <= FLUSH;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rat_flush <= 1'b1;
      hold_cnt  <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (accept) tail <= ptr_next(tail);
          if (commit) begin
            head <= ptr_next(head);
            if (bus.i_commit_rob_addr != head) err <= 1'b1;
          end
          case ({accept, commit})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
          endcase
        end
        FLUSH: begin
          state     <= HOLD;
          rat_flush <= 1'b0;
          hold_cnt  <= HOLD_INIT;
        end
        HOLD: begin
          if (hold_cnt <= 4'd1) begin
            state    <= RUN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rename_ctrl.sv
// Directed scoreboard bench for rename_ctrl: stimulus pushes expected
// allocations and per-cycle status; a negedge monitor pops and compares.
module tb_rename_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc_n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  rename_ctrl_if #(.ROBSIZE(8)) bus ();

  rename_ctrl #(.ROBSIZE(8), .ROB_DEPTH(8), .HOLD_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] tag;
    logic       we;
    logic [4:0] rd;
  } alloc_t;

  typedef struct {
    string      name;
    int         cyc;
    logic       ready;
    int         count;
    logic       err;
    logic       flush;
    logic [7:0] tail;
  } stat_t;

  alloc_t aq[$];
  stat_t  sq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic drv(input logic r, input logic v, input logic w, input logic [4:0] rd,
                     input logic c, input logic [7:0] ca, input logic f);
    @(posedge clk);
    #1;
    rst                   = r;
    bus.i_valid           = v;
    bus.i_rd_we           = w;
    bus.i_rd              = rd;
    bus.i_commit_en       = c;
    bus.i_commit_rob_addr = ca;
    bus.i_flush           = f;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic exp_a(input logic [7:0] tag, input logic we, input logic [4:0] rd);
    alloc_t a;
    a.cyc = cyc_n; a.tag = tag; a.we = we; a.rd = rd;
    aq.push_back(a);
  endtask

  task automatic exp_s(input string name, input logic ready, input int count,
                       input logic err, input logic flush, input logic [7:0] tail);
    stat_t s;
    s.name = name; s.cyc = cyc_n; s.ready = ready; s.count = count;
    s.err = err; s.flush = flush; s.tail = tail;
    sq.push_back(s);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    alloc_t a;
    stat_t  s;
    if (bus.o_rob_alloc_en) begin
      if (aq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_alloc: got tag %0d expected no allocation (cycle %0d)",
                 bus.o_rob_alloc_addr, cyc_n);
      end else begin
        a = aq.pop_front();
        chk("alloc_cycle", cyc_n, a.cyc);
        chk("alloc_addr", int'(bus.o_rob_alloc_addr), int'(a.tag));
        chk("rat_we", int'(bus.o_rat_we), int'(a.we));
        chk("rat_rd", int'(bus.o_rat_rd), a.we ? int'(a.rd) : 0);
        chk("rat_rob_addr", int'(bus.o_rat_rob_addr), a.we ? int'(a.tag) : 0);
        chk("rat_rob_or_rf", int'(bus.o_rat_rob_or_rf), int'(a.we));
      end
    end else if (aq.size() != 0 && aq[0].cyc <= cyc_n) begin
      a = aq.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_alloc: got no allocation expected tag %0d (cycle %0d)", a.tag, cyc_n);
    end
    while (sq.size() != 0 && sq[0].cyc <= cyc_n) begin
      s = sq.pop_front();
      chk({s.name, ".ready"}, int'(bus.o_ready), int'(s.ready));
      chk({s.name, ".count"}, int'(bus.o_count), s.count);
      chk({s.name, ".err"}, int'(bus.o_err), int'(s.err));
      chk({s.name, ".rat_flush"}, int'(bus.o_rat_flush), int'(s.flush));
      chk({s.name, ".tail"}, int'(bus.o_rob_alloc_addr), int'(s.tail));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_rd_we = 1'b0; bus.i_rd = '0;
    bus.i_commit_en = 1'b0; bus.i_commit_rob_addr = '0; bus.i_flush = 1'b0;
    drv(1'b1, 0, 0, 0, 0, 0, 0);
    drv(1'b1, 0, 0, 0, 0, 0, 0);
    idle();                                   exp_s("after_reset", 1, 0, 0, 0, 0);

    // Single dispatch with a real destination.
    drv(0, 1, 1, 5'd5, 0, 0, 0); exp_a(0, 1, 5'd5); exp_s("disp_rd5", 1, 0, 0, 0, 0);
    idle();                                   exp_s("after_rd5", 1, 1, 0, 0, 1);
    // rd=0 and rd_we=0 allocate but do not write the RAT.
    drv(0, 1, 1, 5'd0, 0, 0, 0); exp_a(1, 0, 5'd0);
    drv(0, 1, 0, 5'd7, 0, 0, 0); exp_a(2, 0, 5'd7); exp_s("disp_nowe", 1, 2, 0, 0, 2);
    idle();                                   exp_s("count3", 1, 3, 0, 0, 3);
    // Dispatch and commit together: occupancy unchanged, both pointers move.
    drv(0, 1, 1, 5'd9, 1, 8'd0, 0); exp_a(3, 1, 5'd9); exp_s("disp_commit", 1, 3, 0, 0, 3);
    idle();                                   exp_s("after_disp_commit", 1, 3, 0, 0, 4);
    drv(0, 1, 1, 5'd1, 0, 0, 0); exp_a(4, 1, 5'd1);
    drv(0, 1, 1, 5'd2, 0, 0, 0); exp_a(5, 1, 5'd2);
    // Flush with a pending request: no accept, then clear, then two hold cycles.
    drv(0, 1, 1, 5'd3, 0, 0, 1);              exp_s("flush_req", 0, 5, 0, 0, 6);
    drv(0, 1, 1, 5'd3, 0, 0, 0);              exp_s("flush_state", 0, 0, 0, 1, 0);
    drv(0, 1, 1, 5'd3, 0, 0, 0);              exp_s("hold1", 0, 0, 0, 0, 0);
    drv(0, 0, 0, 5'd0, 1, 8'd0, 0);           exp_s("hold2", 0, 0, 0, 0, 0);
    idle();                                   exp_s("run_again", 1, 0, 0, 0, 0);
    // Second flush arriving during HOLD restarts the sequence.
    drv(0, 0, 0, 0, 0, 0, 1);                 exp_s("flush2_req", 0, 0, 0, 0, 0);
    idle();                                   exp_s("flush2_state", 0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 1);                 exp_s("hold_reflush", 0, 0, 0, 0, 0);
    idle();                                   exp_s("reflush_state", 0, 0, 0, 1, 0);
    idle();                                   exp_s("rehold1", 0, 0, 0, 0, 0);
    idle();                                   exp_s("rehold2", 0, 0, 0, 0, 0);
    idle();                                   exp_s("rerun", 1, 0, 0, 0, 0);
    // Commit on an empty ROB is ignored.
    drv(0, 0, 0, 0, 1, 8'd0, 0);              exp_s("empty_commit", 1, 0, 0, 0, 0);
    idle();                                   exp_s("after_empty", 1, 0, 0, 0, 0);
    // Out-of-order commit tag sets the sticky error; flush keeps it.
    drv(0, 1, 1, 5'd4, 0, 0, 0); exp_a(0, 1, 5'd4);
    drv(0, 0, 0, 0, 1, 8'd4, 0);              exp_s("bad_commit", 1, 1, 0, 0, 1);
    idle();                                   exp_s("err_set", 1, 0, 1, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 1);
    idle();                                   exp_s("err_flush", 0, 0, 1, 1, 0);
    idle(); idle();
    idle();                                   exp_s("err_sticky", 1, 0, 1, 0, 0);
    // Reset clears the error; fill the ROB to the wrap point.
    drv(1, 0, 0, 0, 0, 0, 0);
    idle();                                   exp_s("reset2", 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drv(0, 1, 1, 5'(i + 10), 0, 0, 0); exp_a(8'(i), 1, 5'(i + 10));
    end
    drv(0, 1, 1, 5'd20, 1, 8'd0, 0);          exp_s("full_commit", 0, 8, 0, 0, 0);
    idle();                                   exp_s("after_full", 1, 7, 0, 0, 0);
    drv(0, 1, 1, 5'd21, 0, 0, 0); exp_a(0, 1, 5'd21);
    idle();                                   exp_s("refull", 0, 8, 0, 0, 1);
    // Reset during HOLD returns straight to RUN without a flush pulse.
    drv(0, 0, 0, 0, 0, 0, 1);
    idle();                                   exp_s("flush3_state", 0, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0);                 exp_s("hold_rst", 0, 0, 0, 0, 0);
    idle();                                   exp_s("after_hold_rst", 1, 0, 0, 0, 0);
    idle();                                   exp_s("quiet", 1, 0, 0, 0, 0);
    idle();
    idle();
    chk("alloc_queue_left", aq.size(), 0);
    chk("status_queue_left", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
